// File: rtl/receiver_pkg.sv
// Shared constants, state type and frame helpers for the PS/2 receiver.
// Optional feature macro used by receiver: RECEIVER_TIMEOUT_EN.
package receiver_pkg;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned CNT_W      = 4;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_REL = 8'hF0;
    localparam logic [7:0] ERR_FC     = 8'hFC;
    localparam logic [7:0] ERR_00     = 8'h00;
    localparam logic [7:0] ERR_FF     = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_e;

    // Start low, stop high, odd parity over scan byte plus parity bit.
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
        return (f[0] == 1'b0) && (f[FRAME_BITS-1] == 1'b1) && (^f[9:1] == 1'b1);
    endfunction

    // Keyboard-reported error / self-test-failure codes.
    function automatic logic is_err_code(input logic [7:0] b);
        return (b == ERR_FC) || (b == ERR_00) || (b == ERR_FF);
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronizes ps2_clk/ps2_data into clk and flags ps2_clk falling edges.
// Ports:
//   clk, rst_n   : system clock, async active-low reset
//   ps2_clk_i    : raw PS/2 clock (asynchronous)
//   ps2_data_i   : raw PS/2 data (asynchronous)
//   data_o       : synchronized data, aligned with fall_o
//   fall_o       : one-cycle pulse per synchronized ps2_clk falling edge
// SYNC_STAGES must be at least 2.
module ps2_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic data_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;

    // Synchronizer chains reset to the idle-bus level (high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= {SYNC_STAGES{1'b1}};
            data_sync_q <= {SYNC_STAGES{1'b1}};
            clk_prev_q  <= 1'b1;
            data_o      <= 1'b1;
            fall_o      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
            fall_o      <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
            data_o      <= data_sync_q[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/receiver.sv
// PS/2 keyboard frame receiver: assembles 11-bit frames, validates them,
// tracks E0/F0 prefixes and reports keyboard error conditions.
// Ports:
//   clk, rst        : system clock, async active-low reset
//   ps2_clk/data    : raw PS/2 bus from keyboard
//   data            : last valid raw frame {stop, parity, byte, start}
//   data_latch      : one-cycle pulse when data and flags update
//   reset_required  : sticky error flag
//   release_key     : latched byte was preceded by F0
//   extended_code   : latched byte was preceded by E0
// Optional: define RECEIVER_TIMEOUT_EN to abort stalled frames after
// TIMEOUT_CYCLES clk cycles without a ps2_clk falling edge.
module receiver
    import receiver_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    output logic [FRAME_BITS-1:0] data,
    output logic                  data_latch,
    output logic                  reset_required,
    output logic                  release_key,
    output logic                  extended_code
);

    logic sdata;
    logic sfall;

    ps2_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst),
        .ps2_clk_i (ps2_clk),
        .ps2_data_i(ps2_data),
        .data_o    (sdata),
        .fall_o    (sfall)
    );

    rx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BITS-1:0] data_q, data_d;
    logic                  latch_q, latch_d;
    logic                  rr_q, rr_d;
    logic                  rel_q, rel_d;
    logic                  ext_q, ext_d;
    logic                  rel_pend_q, rel_pend_d;
    logic                  ext_pend_q, ext_pend_d;
    logic [FRAME_BITS-1:0] frame_c;
    logic [7:0]            scan_c;

    // New bit enters at the top; after 11 shifts the start bit sits in bit 0.
    assign frame_c = {sdata, shift_q[FRAME_BITS-1:1]};
    assign scan_c  = frame_c[8:1];

`ifdef RECEIVER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            latch_q    <= 1'b0;
            rr_q       <= 1'b0;
            rel_q      <= 1'b0;
            ext_q      <= 1'b0;
            rel_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
`ifdef RECEIVER_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            latch_q    <= latch_d;
            rr_q       <= rr_d;
            rel_q      <= rel_d;
            ext_q      <= ext_d;
            rel_pend_q <= rel_pend_d;
            ext_pend_q <= ext_pend_d;
`ifdef RECEIVER_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    // Frame FSM: bit collection, validation, prefix and error handling.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        latch_d    = 1'b0;
        rr_d       = rr_q;
        rel_d      = rel_q;
        ext_d      = ext_q;
        rel_pend_d = rel_pend_q;
        ext_pend_d = ext_pend_q;
`ifdef RECEIVER_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (sfall) begin
                    shift_d = frame_c;
                    cnt_d   = CNT_W'(1);
                    state_d = RECV;
`ifdef RECEIVER_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            RECV: begin
                if (sfall) begin
                    shift_d = frame_c;
`ifdef RECEIVER_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                    if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        if (frame_ok(frame_c)) begin
                            if (scan_c == PREFIX_EXT) begin
                                ext_pend_d = 1'b1;
                            end else if (scan_c == PREFIX_REL) begin
                                rel_pend_d = 1'b1;
                            end else begin
                                data_d     = frame_c;
                                latch_d    = 1'b1;
                                ext_d      = ext_pend_q;
                                rel_d      = rel_pend_q;
                                ext_pend_d = 1'b0;
                                rel_pend_d = 1'b0;
                                rr_d       = is_err_code(scan_c);
                            end
                        end else begin
                            rr_d       = 1'b1;
                            ext_pend_d = 1'b0;
                            rel_pend_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef RECEIVER_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    tmo_d      = '0;
                    rr_d       = 1'b1;
                    ext_pend_d = 1'b0;
                    rel_pend_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data           = data_q;
    assign data_latch     = latch_q;
    assign reset_required = rr_q;
    assign release_key    = rel_q;
    assign extended_code  = ext_q;

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: table of PS/2 frames with expected outputs,
// plus reset-mid-frame and (when RECEIVER_TIMEOUT_EN is defined) timeout cases.
module tb_receiver;

    logic        clk;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] data;
    logic        data_latch;
    logic        reset_required;
    logic        release_key;
    logic        extended_code;

    receiver #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .data          (data),
        .data_latch    (data_latch),
        .reset_required(reset_required),
        .release_key   (release_key),
        .extended_code (extended_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Latch pulse monitor: total count and longest high run.
    int latch_total = 0;
    int run_len     = 0;
    int max_run     = 0;
    always @(negedge clk) begin
        if (data_latch) begin
            latch_total = latch_total + 1;
            run_len     = run_len + 1;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    typedef struct {
        logic [7:0]  code;
        logic        bad_par;
        int          exp_latch;
        logic [10:0] exp_data;
        logic        exp_rr;
        logic        exp_rel;
        logic        exp_ext;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip);
        logic [10:0] bits;
        logic        par;
        par  = ~(^b) ^ flip;
        bits = {1'b1, par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(bits[i]);
        repeat (12) @(negedge clk);
    endtask

    task automatic check_outputs(input string tag, input logic [10:0] d, input logic rr,
                                 input logic rel, input logic ext);
        check({tag, ".data"}, 32'(data), 32'(d));
        check({tag, ".reset_required"}, 32'(reset_required), 32'(rr));
        check({tag, ".release_key"}, 32'(release_key), 32'(rel));
        check({tag, ".extended_code"}, 32'(extended_code), 32'(ext));
    endtask

    initial begin
        int base;

        vecs[0]  = '{8'h1C, 1'b0, 1, 11'h438, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'hE0, 1'b0, 0, 11'h438, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{8'hF0, 1'b0, 0, 11'h438, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{8'h75, 1'b0, 1, 11'h4EA, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{8'h1C, 1'b0, 1, 11'h438, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'h1C, 1'b1, 0, 11'h438, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{8'h1C, 1'b0, 1, 11'h438, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{8'hFC, 1'b0, 1, 11'h7F8, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{8'h1C, 1'b0, 1, 11'h438, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{8'hE0, 1'b0, 0, 11'h438, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{8'h75, 1'b1, 0, 11'h438, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{8'h1C, 1'b0, 1, 11'h438, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{8'h00, 1'b0, 1, 11'h600, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{8'hFF, 1'b0, 1, 11'h7FE, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{8'hF0, 1'b0, 0, 11'h7FE, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{8'h1C, 1'b0, 1, 11'h438, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{8'h1C, 1'b0, 1, 11'h438, 1'b0, 1'b0, 1'b0};

        // Reset state
        rst      = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset.latch", 32'(data_latch), 32'd0);
        check_outputs("reset", 11'h000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Table of frames
        for (int i = 0; i < 17; i++) begin
            base = latch_total;
            send_frame(vecs[i].code, vecs[i].bad_par);
            check($sformatf("vec%0d.latches", i), 32'(latch_total - base), 32'(vecs[i].exp_latch));
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_rr,
                          vecs[i].exp_rel, vecs[i].exp_ext);
        end

        // Reset in the middle of a frame, after an error left reset_required set
        send_frame(8'h1C, 1'b1);
        check("pre_rst.reset_required", 32'(reset_required), 32'd1);
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst.latch", 32'(data_latch), 32'd0);
        check_outputs("midrst", 11'h000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        base = latch_total;
        send_frame(8'h1C, 1'b0);
        check("postrst.latches", 32'(latch_total - base), 32'd1);
        check_outputs("postrst", 11'h438, 1'b0, 1'b0, 1'b0);

`ifdef RECEIVER_TIMEOUT_EN
        // Stalled partial frame aborts after the timeout
        base = latch_total;
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        repeat (150) @(negedge clk);
        check("tmo.reset_required", 32'(reset_required), 32'd1);
        check("tmo.state_idle", 32'(dut.state_q), 32'(receiver_pkg::IDLE));
        check("tmo.no_latch", 32'(latch_total - base), 32'd0);
        send_frame(8'h1C, 1'b0);
        check("tmo_after.latches", 32'(latch_total - base), 32'd1);
        check_outputs("tmo_after", 11'h438, 1'b0, 1'b0, 1'b0);
`endif

        check("latch_pulse_width", 32'(max_run), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for ps2_clk/ps2_data (min 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 5000: clk cycles without a ps2_clk falling edge before a partial frame aborts.
REQ-003 SHALL have port clk  input  1: system clock; the single clock; all flops on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port ps2_clk  input  1: PS/2 clock from keyboard, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1: PS/2 data from keyboard, asynchronous to clk.
REQ-007 SHALL have port data  output  11: last valid raw frame; [0]=start, [8:1]=scan byte LSB-first, [9]=parity, [10]=stop.
REQ-008 SHALL have port data_latch  output  1: one-cycle pulse when data and flags are updated.
REQ-009 SHALL have port reset_required  output  1: host must reset the keyboard (error seen).
REQ-010 SHALL have port release_key  output  1: latched byte was preceded by F0.
REQ-011 SHALL have port extended_code  output  1: latched byte was preceded by E0.

Function
REQ-012 SHALL pass ps2_clk and ps2_data through SYNC_STAGES flops and detect ps2_clk falling edges on synchronized values.
REQ-013 SHALL sample synchronized ps2_data on each falling edge, shifting in at bit 10 and right-shifting, so the first bit ends in bit 0.
REQ-014 SHALL use states IDLE (bit count 0) and RECV (1-10 bits held); IDLE->RECV on first edge; RECV->IDLE after the 11th bit, on timeout, or on reset.
REQ-015 SHALL treat a frame as valid iff bit0=0, bit10=1 and bits[9:1] have odd parity.
REQ-016 SHALL, for a valid non-prefix byte, update data and flags and pulse data_latch high for exactly one cycle, the cycle after the 11th edge is detected.
REQ-017 SHALL, on valid prefix E0 or F0, set the internal extended or release pending flag, without updating data and without pulsing data_latch.
REQ-018 SHALL copy the pending flags to extended_code and release_key together with data_latch, then clear the pending flags in that same cycle.
REQ-019 SHALL, on an invalid frame, set reset_required, clear pending flags, leave data unchanged, and not pulse data_latch.
REQ-020 SHALL set reset_required on a valid byte 0xFC, 0x00 or 0xFF; that byte SHALL still be latched.
REQ-021 SHALL keep reset_required sticky until reset, or until the next valid non-prefix byte other than 0xFC, 0x00 or 0xFF, which clears it.
REQ-022 SHALL hold data, release_key and extended_code stable between latches.

Reset
REQ-023 SHALL, while rst=0, clear data to 0, all flags and outputs to 0, bit count to 0 and state to IDLE, and load the synchronizer flops with 1 (idle bus).
REQ-024 SHALL discard a frame interrupted by reset; reception restarts at the next start bit after release.

Configuration
REQ-025 SHALL, with RECEIVER_TIMEOUT_EN defined, count clk cycles in RECV since the last edge; on reaching TIMEOUT_CYCLES it SHALL return to IDLE, set reset_required and clear pending flags.
REQ-026 SHALL, without RECEIVER_TIMEOUT_EN, omit the counter entirely and wait indefinitely in RECV; TIMEOUT_CYCLES is then unused.

Structure
REQ-027 SHALL take FRAME_BITS=11, PREFIX_EXT=8'hE0, PREFIX_REL=8'hF0, error codes FC/00/FF and the state typedef from shared package receiver_pkg.
REQ-028 SHALL implement synchronizer plus falling-edge detector as sub-module ps2_sync_edge; the frame FSM stays in receiver.

Verification
REQ-029 SHALL verify: frame for 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1) -> one data_latch, data=11'h438, release_key=0, extended_code=0, reset_required=0.
REQ-030 SHALL verify: frames E0, F0, 0x75 -> exactly one data_latch, with data[8:1]=0x75, extended_code=1, release_key=1; a following 0x1C latches with both flags 0.
REQ-031 SHALL verify: 0x1C with parity bit 1 -> no data_latch, reset_required=1; next valid 0x1C -> latch and reset_required=0.
REQ-032 SHALL verify (RECEIVER_TIMEOUT_EN, TIMEOUT_CYCLES=100): 5 bits then 150 idle cycles -> reset_required=1, state IDLE; next full 0x1C frame latches correctly.
REQ-033 SHALL verify: rst=0 asserted after 6 bits of a frame -> all outputs 0; after release a full 0x1C frame gives data=11'h438.
REQ-034 SHALL verify: valid byte 0xFC -> data_latch with data[8:1]=0xFC and reset_required=1.
